uart_rx: RTL and testbench
==========================

UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 5001, giving clocks per bit period; this matches the transmitter, whose counter runs 0..5000.
REQ-002 SHALL have parameter FIFO_DEPTH, default 4, giving the number of received bytes buffered; it is a power of two.
REQ-003 SHALL have port clock, input, 1 bit: the single clock; all logic is rising-edge.
REQ-004 SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port rx, input, 1 bit: asynchronous serial line, idle high.
REQ-006 SHALL have port data, output, 8 bits: the byte at the head of the FIFO.
REQ-007 SHALL have port valid, output, 1 bit: high when the FIFO is non-empty.
REQ-008 SHALL have port ready, input, 1 bit: consumer accepts the head byte.
REQ-009 SHALL have port frame_err, output, 1 bit: one-cycle pulse when a stop bit samples low.
REQ-010 SHALL have port overrun, output, 1 bit: one-cycle pulse when a good byte is dropped because the FIFO is full.
REQ-011 SHALL have port busy, output, 1 bit: high in every FSM state except IDLE.

Function
REQ-012 SHALL pass rx through a 2-flop synchroniser; all FSM decisions use the synchronised value.
REQ-013 SHALL implement FSM states IDLE, START, DATA and STOP.
REQ-014 In IDLE, a synchronised high-to-low transition SHALL move the FSM to START and clear the bit counter.
REQ-015 In START, after CLKS_PER_BIT/2 clocks (integer division), SHALL sample the line: low -> DATA; high -> IDLE (glitch rejected, no flags raised).
REQ-016 In DATA, SHALL sample every CLKS_PER_BIT clocks, 8 samples in total, LSB first, into shift-register bit index 0..7; after index 7 the FSM SHALL go to STOP.
REQ-017 In STOP, after CLKS_PER_BIT clocks, SHALL sample the line: high -> push the byte; low -> pulse frame_err, discard the byte.
REQ-018 After the STOP sample, the FSM SHALL return to IDLE; a new start bit is recognised only on a fresh high-to-low edge, so a held-low line (break) produces no further frames.
REQ-019 The bit-period counter SHALL be at least 32 bits wide, SHALL reset to 0 on every state change, and SHALL never wrap.
REQ-020 Push latency: valid SHALL rise on the clock after the STOP-sample cycle when the FIFO was empty.
REQ-021 A byte SHALL transfer on every cycle where valid and ready are both high; data SHALL be stable while valid is high and ready is low.
REQ-022 A push while the FIFO is full and no pop occurs SHALL drop the new byte and pulse overrun; the FIFO contents SHALL remain unchanged.
REQ-023 A push and pop in the same cycle while full SHALL both succeed, with no overrun.
REQ-024 A push and pop in the same cycle while the FIFO holds 1 entry SHALL leave valid high with the new byte at the head.
REQ-025 FIFO read and write pointers SHALL wrap modulo FIFO_DEPTH, with full/empty distinguished by an extra pointer bit.

Reset
REQ-026 While reset is low: FSM in IDLE; counters, pointers and shift register 0; synchroniser flops 1; data=0, valid=0, frame_err=0, overrun=0, busy=0.
REQ-027 Reset asserted mid-frame SHALL abort the frame and discard the partial byte and all buffered bytes; after release the receiver waits for a new falling edge.

Structure
REQ-028 A shared package uart_pkg SHALL hold the FSM state encoding (2 bits), the default CLKS_PER_BIT (5001) and the data width (8), for common use by transmitter and receiver.
REQ-029 The FIFO SHALL be a separate sub-module, uart_rx_fifo (parameters: width, depth; interface: push/data_in, pop/data_out, full, empty), instantiated once.

Verification (bench uses CLKS_PER_BIT=16, FIFO_DEPTH=4)
REQ-030 Send 0x68 with a valid stop bit, ready=1 -> valid pulses once with data=0x68; frame_err=0, overrun=0.
REQ-031 Send the 12-byte sequence "hello world!" back-to-back with ready=1 -> 12 bytes received in order, no flags.
REQ-032 Drive a 5-clock low glitch on idle rx -> busy returns low, no valid, no frame_err.
REQ-033 Send 0x55 with the stop bit forced low -> one-cycle frame_err pulse, FIFO stays empty, and no new frame while rx is held low.
REQ-034 Hold ready=0 and send 5 bytes 0x01..0x05 -> overrun pulses on byte 5; then raise ready -> 0x01..0x04 are read out.
REQ-035 Assert reset during bit 3 of 0xA5, release it, then send 0x3C -> only 0x3C is received.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, default bit timing and byte width
// used by both the transmitter and the receiver.
package uart_pkg;

   localparam int DATA_W               = 8;
   localparam int DEFAULT_CLKS_PER_BIT = 5001;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_START = 2'd1,
      ST_DATA  = 2'd2,
      ST_STOP  = 2'd3
   } uart_state_e;

endpackage

// File: rtl/uart_rx_fifo.sv
// Small synchronous FIFO for received bytes; pointers carry one extra wrap bit
// so full and empty can be told apart without a separate count.
module uart_rx_fifo
   import uart_pkg::*;
#(
   parameter int WIDTH = DATA_W,
   parameter int DEPTH = 4
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             push,
   input  logic [WIDTH-1:0] data_in,
   input  logic             pop,
   output logic [WIDTH-1:0] data_out,
   output logic             full,
   output logic             empty
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW:0]      wptr;
   logic [AW:0]      rptr;
   logic             do_push;
   logic             do_pop;

   assign empty    = (wptr == rptr);
   assign full     = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
   assign do_pop   = pop & ~empty;
   // A full FIFO still accepts a push when the head leaves in the same cycle.
   assign do_push  = push & (~full | do_pop);
   assign data_out = empty ? '0 : mem[rptr[AW-1:0]];

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         wptr <= '0;
         rptr <= '0;
      end else begin
         if (do_push) wptr <= wptr + 1'b1;
         if (do_pop)  rptr <= rptr + 1'b1;
      end
   end

   always_ff @(posedge clock) begin
      if (do_push) mem[wptr[AW-1:0]] <= data_in;
   end

endmodule

// File: rtl/uart_rx.sv
// UART receiver: 2-flop synchroniser, start/data/stop FSM sampling mid-bit,
// and a byte FIFO with valid/ready handshake, frame-error and overrun pulses.
module uart_rx
   import uart_pkg::*;
#(
   parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
   parameter int FIFO_DEPTH   = 4
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              rx,
   output logic [DATA_W-1:0] data,
   output logic              valid,
   input  logic              ready,
   output logic              frame_err,
   output logic              overrun,
   output logic              busy
);

   localparam logic [31:0] HALF_BIT = 32'(CLKS_PER_BIT / 2);
   localparam logic [31:0] FULL_BIT = 32'(CLKS_PER_BIT);

   function automatic logic [31:0] sat_inc(input logic [31:0] v);
      return (v == '1) ? v : v + 32'd1;
   endfunction

   logic              rx_p0;
   logic              rx_p1;
   logic              rx_p2;
   uart_state_e       state;
   uart_state_e       state_nx;
   logic [31:0]       cnt;
   logic [2:0]        bit_idx;
   logic [DATA_W-1:0] shreg;
   logic              cnt_clr;
   logic              samp_bit;
   logic              push_req;
   logic              ferr_nx;
   logic              pop;
   logic              full;
   logic              empty;

   // Synchroniser (p0, p1) plus one history flop (p2) for edge detection.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         rx_p0 <= 1'b1;
         rx_p1 <= 1'b1;
         rx_p2 <= 1'b1;
      end else begin
         rx_p0 <= rx;
         rx_p1 <= rx_p0;
         rx_p2 <= rx_p1;
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) state <= ST_IDLE;
      else        state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      cnt_clr  = 1'b0;
      samp_bit = 1'b0;
      push_req = 1'b0;
      ferr_nx  = 1'b0;
      case (state)
         ST_IDLE: begin
            if (rx_p2 && !rx_p1) state_nx = ST_START;
         end
         ST_START: begin
            if (cnt == HALF_BIT - 32'd1) state_nx = rx_p1 ? ST_IDLE : ST_DATA;
         end
         ST_DATA: begin
            if (cnt == FULL_BIT - 32'd1) begin
               samp_bit = 1'b1;
               cnt_clr  = 1'b1;
               if (bit_idx == 3'd7) state_nx = ST_STOP;
            end
         end
         ST_STOP: begin
            if (cnt == FULL_BIT - 32'd1) begin
               state_nx = ST_IDLE;
               push_req = rx_p1;
               ferr_nx  = ~rx_p1;
            end
         end
         default: state_nx = ST_IDLE;
      endcase
      if (state_nx != state) cnt_clr = 1'b1;
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         cnt       <= '0;
         bit_idx   <= '0;
         shreg     <= '0;
         frame_err <= 1'b0;
         overrun   <= 1'b0;
      end else begin
         cnt <= cnt_clr ? '0 : sat_inc(cnt);
         if (state == ST_IDLE && state_nx == ST_START) begin
            bit_idx <= '0;
         end else if (samp_bit) begin
            shreg[bit_idx] <= rx_p1;
            bit_idx        <= bit_idx + 3'd1;
         end
         frame_err <= ferr_nx;
         overrun   <= push_req & full & ~pop;
      end
   end

   assign valid = ~empty;
   assign pop   = valid & ready;
   assign busy  = (state != ST_IDLE);

   uart_rx_fifo #(
      .WIDTH(DATA_W),
      .DEPTH(FIFO_DEPTH)
   ) u_fifo (
      .clock   (clock),
      .reset   (reset),
      .push    (push_req),
      .data_in (shreg),
      .pop     (pop),
      .data_out(data),
      .full    (full),
      .empty   (empty)
   );

endmodule

// File: tb/tb_uart_rx.sv
// Directed and randomized bench for uart_rx; a queue-based reference model
// predicts delivered bytes, frame errors and overruns from the frames sent.
module tb_uart_rx;

   localparam int CPB   = 16;
   localparam int DEPTH = 4;

   logic       clock;
   logic       reset;
   logic       rx;
   logic [7:0] data;
   logic       valid;
   logic       ready;
   logic       frame_err;
   logic       overrun;
   logic       busy;

   int         checks;
   int         errors;

   logic [7:0] got_q[$];
   int         ferr_cnt;
   int         ovr_cnt;

   logic [7:0] exp_q[$];
   int         exp_ferr;
   int         exp_ovr;
   int         mdl_cnt;
   int         got_base;
   int         ferr_base;
   int         ovr_base;

   uart_rx #(
      .CLKS_PER_BIT(CPB),
      .FIFO_DEPTH  (DEPTH)
   ) dut (
      .clock    (clock),
      .reset    (reset),
      .rx       (rx),
      .data     (data),
      .valid    (valid),
      .ready    (ready),
      .frame_err(frame_err),
      .overrun  (overrun),
      .busy     (busy)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Observer: transfers and pulse widths counted on the inactive edge.
   initial begin
      ferr_cnt = 0;
      ovr_cnt  = 0;
      forever begin
         @(negedge clock);
         if (valid && ready) got_q.push_back(data);
         if (frame_err) ferr_cnt++;
         if (overrun) ovr_cnt++;
      end
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clock);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Drives one frame; the model decides what the receiver must do with it.
   task automatic send_frame(input logic [7:0] b, input logic stop_ok);
      rx = 1'b0;
      tick(CPB);
      for (int i = 0; i < 8; i++) begin
         rx = b[i];
         tick(CPB);
      end
      rx = stop_ok;
      tick(CPB);
      if (!stop_ok) begin
         exp_ferr++;
      end else if (!ready) begin
         if (mdl_cnt == DEPTH) begin
            exp_ovr++;
         end else begin
            mdl_cnt++;
            exp_q.push_back(b);
         end
      end else begin
         exp_q.push_back(b);
      end
   endtask

   task automatic begin_phase();
      exp_q.delete();
      exp_ferr  = 0;
      exp_ovr   = 0;
      mdl_cnt   = 0;
      got_base  = got_q.size();
      ferr_base = ferr_cnt;
      ovr_base  = ovr_cnt;
   endtask

   task automatic end_phase(input string tag);
      int n;
      n = got_q.size() - got_base;
      chk({tag, " count"}, n, exp_q.size());
      for (int i = 0; i < exp_q.size(); i++) begin
         if (i < n) chk($sformatf("%s byte%0d", tag, i), got_q[got_base + i], exp_q[i]);
      end
      chk({tag, " frame_err"}, ferr_cnt - ferr_base, exp_ferr);
      chk({tag, " overrun"}, ovr_cnt - ovr_base, exp_ovr);
   endtask

   initial begin
      string      msg;
      logic [7:0] b;
      logic [7:0] a5;
      logic       st;

      checks = 0;
      errors = 0;
      reset  = 1'b0;
      rx     = 1'b1;
      ready  = 1'b1;
      msg    = "hello world!";
      a5     = 8'hA5;
      #1;
      tick(3);
      chk("rst data", data, 8'h00);
      chk("rst valid", valid, 1'b0);
      chk("rst frame_err", frame_err, 1'b0);
      chk("rst overrun", overrun, 1'b0);
      chk("rst busy", busy, 1'b0);
      reset = 1'b1;
      tick(5);

      // Single byte
      begin_phase();
      send_frame(8'h68, 1'b1);
      tick(40);
      end_phase("single68");

      // Back-to-back string
      begin_phase();
      for (int i = 0; i < msg.len(); i++) send_frame(msg[i], 1'b1);
      tick(40);
      end_phase("hello");

      // Short glitch on idle line
      begin_phase();
      rx = 1'b0;
      tick(5);
      chk("glitch busy_mid", busy, 1'b1);
      rx = 1'b1;
      tick(40);
      chk("glitch busy_end", busy, 1'b0);
      chk("glitch valid", valid, 1'b0);
      end_phase("glitch");

      // Bad stop bit followed by a held-low break
      begin_phase();
      send_frame(8'h55, 1'b0);
      rx = 1'b0;
      tick(8 * CPB);
      chk("break busy", busy, 1'b0);
      chk("break valid", valid, 1'b0);
      end_phase("ferr");
      rx = 1'b1;
      tick(40);
      chk("break release busy", busy, 1'b0);

      // Overrun with consumer stalled
      begin_phase();
      ready = 1'b0;
      for (int i = 1; i <= 4; i++) send_frame(8'(i), 1'b1);
      tick(20);
      chk("ovr valid", valid, 1'b1);
      chk("ovr head", data, 8'h01);
      chk("ovr none_yet", ovr_cnt - ovr_base, 0);
      send_frame(8'h05, 1'b1);
      tick(20);
      chk("ovr head_stable", data, 8'h01);
      ready   = 1'b1;
      mdl_cnt = 0;
      tick(20);
      chk("ovr drained", valid, 1'b0);
      end_phase("overrun");

      // Randomized bytes, gaps and occasional bad stop bits
      begin_phase();
      for (int i = 0; i < 12; i++) begin
         b  = 8'($urandom);
         st = ($urandom_range(0, 4) != 0);
         send_frame(b, st);
         rx = 1'b1;
         if (!st) tick($urandom_range(4, 30));
         else     tick($urandom_range(0, 30));
      end
      tick(40);
      end_phase("random");

      // Reset in the middle of a frame with a byte already buffered
      begin_phase();
      ready = 1'b0;
      send_frame(8'h77, 1'b1);
      tick(20);
      chk("midrst buffered", valid, 1'b1);
      rx = 1'b0;
      tick(CPB);
      for (int i = 0; i < 3; i++) begin
         rx = a5[i];
         tick(CPB);
      end
      rx = a5[3];
      tick(CPB / 2);
      reset = 1'b0;
      rx    = 1'b1;
      repeat (mdl_cnt) void'(exp_q.pop_back());
      mdl_cnt = 0;
      tick(1);
      chk("midrst busy_in", busy, 1'b0);
      chk("midrst valid_in", valid, 1'b0);
      tick(4);
      reset = 1'b1;
      tick(40);
      chk("midrst busy_after", busy, 1'b0);
      chk("midrst valid_after", valid, 1'b0);
      ready = 1'b1;
      send_frame(8'h3C, 1'b1);
      tick(40);
      end_phase("midrst");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
